// File: rtl/fpu_req_arbiter.sv
// fpu_req_arbiter: four-requester round-robin front end for one shared FPU core.
// Optional build macro FPU_ARB_OPCHK_EN enables the illegal-opcode check
// (op > 3 answered directly with rsp_err=1, never issued to the core).
module fpu_req_arbiter (
    input  logic         Clk,
    input  logic         RstN,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    input  logic [127:0] req_a,
    input  logic [127:0] req_b,
    input  logic [15:0]  req_op,
    output logic [31:0]  core_a,
    output logic [31:0]  core_b,
    output logic [3:0]   core_op,
    input  logic [31:0]  core_result,
    input  logic         core_exc,
    input  logic         core_ovf,
    input  logic         core_unf,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [1:0]   rsp_id,
    output logic [31:0]  rsp_result,
    output logic         rsp_exc,
    output logic         rsp_ovf,
    output logic         rsp_unf,
    output logic         rsp_err
);

    localparam int unsigned N_REQ        = 4;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned OP_W         = 4;
    localparam logic [3:0]  OP_NOP       = 4'hF;
    localparam logic [3:0]  OP_MAX_LEGAL = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  last_grant;
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic [31:0] grant_a;
    logic [31:0] grant_b;
    logic [3:0]  grant_op;
    logic        grant_illegal;

    // Round-robin search starting one past the last winner; only offered in IDLE.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant;
        cand        = '0;
        req_ready   = '0;
        if (state == IDLE) begin
            for (int unsigned k = 1; k <= N_REQ; k++) begin
                cand = last_grant + 2'(k);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Winner's payload slices.
    always_comb begin
        grant_a  = req_a[DATA_W*grant_idx +: DATA_W];
        grant_b  = req_b[DATA_W*grant_idx +: DATA_W];
        grant_op = req_op[OP_W*grant_idx +: OP_W];
    end

`ifdef FPU_ARB_OPCHK_EN
    assign grant_illegal = (grant_op > OP_MAX_LEGAL);

    // Error flag is decided at accept and held through the response.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            rsp_err <= 1'b0;
        end else if (state == IDLE && grant_found) begin
            rsp_err <= grant_illegal;
        end
    end
`else
    assign grant_illegal = 1'b0;
    assign rsp_err       = 1'b0;
`endif

    // Control FSM with registered core and response outputs.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            core_a     <= '0;
            core_b     <= '0;
            core_op    <= OP_NOP;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_exc    <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_unf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        last_grant <= grant_idx;
                        rsp_id     <= grant_idx;
                        if (grant_illegal) begin
                            rsp_result <= '0;
                            rsp_exc    <= 1'b0;
                            rsp_ovf    <= 1'b0;
                            rsp_unf    <= 1'b0;
                            rsp_valid  <= 1'b1;
                            state      <= RESP;
                        end else begin
                            core_a  <= grant_a;
                            core_b  <= grant_b;
                            core_op <= grant_op;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    core_op <= OP_NOP;
                    state   <= CAPT;
                end
                CAPT: begin
                    rsp_result <= core_result;
                    rsp_exc    <= core_exc;
                    rsp_ovf    <= core_ovf;
                    rsp_unf    <= core_unf;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Self-checking bench for fpu_req_arbiter: transaction-level reference model,
// a mock FPU core built on real arithmetic, directed cases plus random traffic.
module tb_fpu_req_arbiter;

    logic         Clk = 1'b0;
    logic         RstN = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [15:0]  req_op = '0;
    logic [31:0]  core_a, core_b;
    logic [3:0]   core_op;
    logic [31:0]  core_result = '0;
    logic         core_exc = 1'b0, core_ovf = 1'b0, core_unf = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         rsp_exc, rsp_ovf, rsp_unf, rsp_err;

    fpu_req_arbiter dut (
        .Clk(Clk), .RstN(RstN),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .core_a(core_a), .core_b(core_b), .core_op(core_op),
        .core_result(core_result), .core_exc(core_exc), .core_ovf(core_ovf), .core_unf(core_unf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_exc(rsp_exc), .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf),
        .rsp_err(rsp_err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- mock FPU core (single precision via reals) ----------------
    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [31:0] x);
        int  e = int'(x[30:23]);
        real r;
        if (e == 0) return 0.0;
        r = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(e - 127);
        return x[31] ? -r : r;
    endfunction

    // Returns {exc, ovf, unf, result}.
    function automatic logic [34:0] fp_mock(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        real         x, y, r;
        logic [63:0] d;
        int          e;
        x = to_real(a);
        y = to_real(b);
        case (op)
            4'd0: r = x + y;
            4'd1: r = x - y;
            4'd2: r = x * y;
            4'd3: begin
                if (y == 0.0) return {3'b100, 32'h0};
                r = x / y;
            end
            default: return {3'b000, a ^ b};
        endcase
        if (r == 0.0) return {3'b000, 32'h0};
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e > 254) return {3'b110, d[63], 8'hFF, 23'h0};
        if (e < 1)   return {3'b101, d[63], 31'h0};
        return {3'b000, d[63], 8'(e), d[51:29]};
    endfunction

    // Core registers its result one edge after seeing a non-NOP op.
    always @(posedge Clk) begin
        if (core_op != 4'hF) begin
            {core_exc, core_ovf, core_unf, core_result} <= fp_mock(core_a, core_b, core_op);
        end
    end

    // ---------------- reference model ----------------
    int          m_owner = -1;       // requester being served, -1 when free
    int          m_age = 0;          // edges since accept, accept edge = 1
    bit          m_illegal = 1'b0;
    logic [3:0]  m_op = '0;
    logic [1:0]  m_id = '0;
    logic [1:0]  m_last = 2'd3;
    logic [31:0] m_core_a = '0, m_core_b = '0;
    logic [34:0] m_rsp = '0;
    bit          m_err = 1'b0;
    int          wait_cnt [4];
    int          grant_log [$];
    int          cyc = 0, acc_cyc = 0, last_lat = 0, core_active_cnt = 0;
    bit          prev_rv = 1'b0;

    function automatic int rr_pick(input logic [1:0] last, input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int idx = (int'(last) + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int resp_age();
        return m_illegal ? 1 : 3;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_age    = 0;
        m_illegal = 1'b0;
        m_last   = 2'd3;
        m_core_a = '0;
        m_core_b = '0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    endtask

    task automatic model_compare();
        int          w;
        logic [3:0]  er;
        logic [3:0]  eop;
        bit          rv;
        er  = '0;
        w   = (m_owner < 0) ? rr_pick(m_last, req_valid) : -1;
        if (w >= 0) er[w] = 1'b1;
        eop = (m_owner >= 0 && !m_illegal && m_age == 1) ? m_op : 4'hF;
        rv  = (m_owner >= 0) && (m_age >= resp_age());
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("core_op", 32'(core_op), 32'(eop));
        chk("core_a", core_a, m_core_a);
        chk("core_b", core_b, m_core_b);
        chk("rsp_valid", 32'(rsp_valid), 32'(rv));
        if (rv) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_result", rsp_result, m_rsp[31:0]);
            chk("rsp_flags", 32'({rsp_exc, rsp_ovf, rsp_unf}), 32'(m_rsp[34:32]));
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        if (rsp_valid && !prev_rv) last_lat = cyc - acc_cyc + 1;
        prev_rv = rsp_valid;
        if (core_op != 4'hF) core_active_cnt++;
    endtask

    task automatic model_step();
        int w;
        if (m_owner >= 0) begin
            if (m_age >= resp_age() && rsp_ready) m_owner = -1;
            else m_age++;
        end else begin
            w = rr_pick(m_last, req_valid);
            if (w >= 0) begin
                for (int i = 0; i < 4; i++) begin
                    if (i != w && req_valid[i]) begin
                        wait_cnt[i]++;
                        chk("fair_wait", (wait_cnt[i] <= 3) ? 32'd1 : 32'd0, 32'd1);
                    end
                end
                wait_cnt[w] = 0;
                grant_log.push_back(w);
                m_owner = w;
                m_id    = 2'(w);
                m_last  = 2'(w);
                m_age   = 1;
                acc_cyc = cyc;
                m_op    = req_op[4*w +: 4];
`ifdef FPU_ARB_OPCHK_EN
                m_illegal = (m_op > 4'd3);
`else
                m_illegal = 1'b0;
`endif
                if (m_illegal) begin
                    m_rsp = '0;
                    m_err = 1'b1;
                end else begin
                    m_core_a = req_a[32*w +: 32];
                    m_core_b = req_b[32*w +: 32];
                    m_rsp    = fp_mock(m_core_a, m_core_b, m_op);
                    m_err    = 1'b0;
                end
            end
        end
    endtask

    // Compare on falling edges, advance the model on rising edges.
    initial begin
        forever begin
            @(negedge Clk);
            if (!RstN) model_reset();
            model_compare();
            @(posedge Clk);
            cyc++;
            if (RstN) model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[4*i +: 4]  = op;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_accept(input int i, input int max);
        for (int n = 0; n < max; n++) begin
            @(negedge Clk);
            if (req_valid[i] && req_ready[i]) begin
                @(posedge Clk);
                #1;
                req_valid[i] = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int max);
        for (int n = 0; n < max; n++) begin
            @(negedge Clk);
            if (rsp_valid) return;
        end
        chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_grants(input int count, input int max);
        for (int n = 0; n < max; n++) begin
            if (grant_log.size() >= count) return;
            @(posedge Clk);
            #1;
        end
        chk("grant_timeout", 32'(grant_log.size()), 32'(count));
    endtask

    // Let held requests finish, dropping each one as it is accepted.
    task automatic drain(input int max);
        logic [3:0] acc;
        rsp_ready = 1'b1;
        for (int n = 0; n < max; n++) begin
            @(negedge Clk);
            acc = req_valid & req_ready;
            if (req_valid == 4'b0 && m_owner < 0) return;
            @(posedge Clk);
            #1;
            req_valid = req_valid & ~acc;
        end
        chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        @(posedge Clk);
        #2 RstN = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #2 RstN = 1'b1;
    endtask

    function automatic logic [31:0] rand_fp();
        if ($urandom_range(0, 15) == 0) return 32'h0;
        return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
    endfunction

    function automatic logic [3:0] rand_op();
        return ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 14));
    endfunction

    task automatic run_random(input int n);
        logic [3:0] acc;
        for (int c = 0; c < n; c++) begin
            @(negedge Clk);
            acc = req_valid & req_ready;
            @(posedge Clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) set_req(i, rand_fp(), rand_fp(), rand_op());
                    else req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int glen;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        // Reset values
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("rst_core_op", 32'(core_op), 32'hF);
        chk("rst_core_a", core_a, 32'h0);
        chk("rst_core_b", core_b, 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'h0);
        chk("rst_rsp_flags", 32'({rsp_exc, rsp_ovf, rsp_unf, rsp_err}), 32'd0);
        #1 RstN = 1'b1;

        // Single request: 1.0 + 2.0 from requester 2
        @(posedge Clk);
        #1;
        rsp_ready = 1'b1;
        set_req(2, 32'h3F800000, 32'h40000000, 4'd0);
        wait_accept(2, 10);
        wait_rsp(10);
        #1;
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_result", rsp_result, 32'h40400000);
        chk("single_latency", 32'(last_lat), 32'd3);
        drain(20);

        // Multiply overflow: 2^127 * 2^127
        @(posedge Clk);
        #1;
        set_req(0, 32'h7F000000, 32'h7F000000, 4'd2);
        wait_accept(0, 10);
        wait_rsp(10);
        #1;
        chk("ovf_flag", 32'(rsp_ovf), 32'd1);
        chk("ovf_exc", 32'(rsp_exc), 32'd1);
        chk("ovf_result", rsp_result, 32'h7F800000);
        drain(20);

        // Backpressure: 2.0 * 3.0 from requester 1, response held 5 cycles
        @(posedge Clk);
        #1;
        rsp_ready = 1'b0;
        set_req(1, 32'h40000000, 32'h40400000, 4'd2);
        wait_accept(1, 10);
        wait_rsp(10);
        #1;
        set_req(0, 32'h3F800000, 32'h3F800000, 4'd0);
        set_req(3, 32'h40000000, 32'h3F800000, 4'd1);
        glen = grant_log.size();
        for (int n = 0; n < 5; n++) begin
            @(negedge Clk);
            #1;
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_id", 32'(rsp_id), 32'd1);
            chk("bp_rsp_result", rsp_result, 32'h40C00000);
        end
        chk("bp_no_grant", 32'(grant_log.size()), 32'(glen));
        @(posedge Clk);
        #1;
        rsp_ready = 1'b1;
        wait_grants(glen + 1, 10);
        if (grant_log.size() > glen) chk("bp_next_grant", 32'(grant_log[glen]), 32'd3);
        drain(40);

        // Contention: all four held valid from reset
        @(posedge Clk);
        #2 RstN = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 32'h3F800000 + 32'(i), 32'h40000000, 4'(i));
        @(negedge Clk);
        glen = grant_log.size();
        #2 RstN = 1'b1;
        wait_grants(glen + 5, 40);
        for (int k = 0; k < 5; k++) begin
            if (grant_log.size() > glen + k)
                chk("order", 32'(grant_log[glen + k]), 32'(exp_order[k]));
        end
        drain(60);

        // Reset while the core result is being captured
        @(posedge Clk);
        #1;
        set_req(2, 32'h40000000, 32'h40000000, 4'd0);
        wait_accept(2, 10);
        @(posedge Clk);
        #2 RstN = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_core_op", 32'(core_op), 32'hF);
        for (int i = 0; i < 4; i++) set_req(i, 32'h40400000, 32'h3F800000, 4'd1);
        @(negedge Clk);
        glen = grant_log.size();
        #2 RstN = 1'b1;
        wait_grants(glen + 1, 10);
        if (grant_log.size() > glen) chk("midrst_first", 32'(grant_log[glen]), 32'd0);
        drain(60);

`ifdef FPU_ARB_OPCHK_EN
        // Illegal opcode from requester 1
        begin
            int active0;
            active0 = core_active_cnt;
            @(posedge Clk);
            #1;
            set_req(1, 32'h12345678, 32'h9ABCDEF0, 4'd7);
            wait_accept(1, 10);
            wait_rsp(10);
            #1;
            chk("illegal_latency", 32'(last_lat), 32'd1);
            chk("illegal_err", 32'(rsp_err), 32'd1);
            chk("illegal_result", rsp_result, 32'h0);
            chk("illegal_id", 32'(rsp_id), 32'd1);
            drain(20);
            chk("illegal_core_idle", 32'(core_active_cnt), 32'(active0));
        end
`endif

        // Random traffic
        run_random(3000);
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
